pipe_stall_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines load-use hazards,

---
 rtl/pipe_stall_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Merges data-memory wait states, multi-cycle mul/div occupancy, taken-branch
// flushes and load-use hazards into one set of pipeline-register enables.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined;
// otherwise stall_cnt and flush_cnt are tied to zero.
module pipe_stall_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             ex_br_taken,
  input  logic             ex_md_start,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             idex_wr,
  output logic             exmem_wr,
  output logic             memwb_wr,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // The md counter holds the MD cycles still to run, including the current one.
  localparam int              MD_W    = $clog2(MD_LATENCY);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY - 1);
  localparam logic [MD_W-1:0] MD_ONE  = MD_W'(1);

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  state_e          eff_state;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  logic            mem_stall;
  logic            load_use;

  assign mem_stall = mem_req & ~dmem_ready;
  assign load_use  = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Next-state and control decode; MEM stall > MD sequence > branch > load-use.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    // A cycle in MEM_WAIT without a stall behaves exactly like the saved state.
    eff_state    = (state_q == MEM_WAIT) ? ret_q : state_q;
    state_d      = eff_state;
    ret_d        = ret_q;
    md_cnt_d     = md_cnt_q;
    pc_wr        = 1'b1;
    ifid_wr      = 1'b1;
    idex_wr      = 1'b1;
    exmem_wr     = 1'b1;
    memwb_wr     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;

    if (mem_stall) begin
      // Freeze the whole pipe and the md counter; remember where to resume.
      pc_wr    = 1'b0;
      ifid_wr  = 1'b0;
      idex_wr  = 1'b0;
      exmem_wr = 1'b0;
      memwb_wr = 1'b0;
      md_busy  = (eff_state == MD_WAIT);
      state_d  = MEM_WAIT;
      ret_d    = eff_state;
    end else if (eff_state == MD_WAIT) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      idex_wr = 1'b0;
      md_busy = 1'b1;
      if (md_cnt_q == MD_ONE) begin
        md_done  = 1'b1;
        md_cnt_d = '0;
        state_d  = RUN;
      end else begin
        exmem_bubble = 1'b1;
        md_cnt_d     = md_cnt_q - MD_ONE;
      end
    end else if (ex_br_taken) begin
      // The ID instruction is discarded, so any load-use match is moot.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_md_start) begin
      // First of MD_LATENCY EX cycles; the rest are counted in MD_WAIT.
      pc_wr        = 1'b0;
      ifid_wr      = 1'b0;
      idex_wr      = 1'b0;
      exmem_bubble = 1'b1;
      md_busy      = 1'b1;
      md_cnt_d     = MD_LOAD;
      state_d      = MD_WAIT;
    end else if (load_use) begin
      pc_wr       = 1'b0;
      ifid_wr     = 1'b0;
      idex_bubble = 1'b1;
    end

    if (!rst_n) begin
      pc_wr        = 1'b0;
      ifid_wr      = 1'b0;
      idex_wr      = 1'b0;
      exmem_wr     = 1'b0;
      memwb_wr     = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      md_busy      = 1'b0;
      md_done      = 1'b0;
    end
  end

  // Sequencer state registers with synchronous reset.
  // NOTE: sequential state uses <= so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      ret_q    <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: cycles with the PC held, and branch flushes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_wr && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
